secuenciador_banco: RTL and testbench



---
 rtl/secuenciador_pkg.sv | 35 +++
 rtl/secuenciador_banco_decodificador.sv | 60 ++++++
 rtl/secuenciador_banco.sv | 190 +++++++++++++++++++
 tb/tb_secuenciador_banco.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_pkg.sv
// Shared types and constants for the register-file/ALU sequencer:
// FSM states, ALU operation codes, opcode/funct values and register legality.
package secuenciador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } estado_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Only $zero and $t0..$t5 exist in the attached register file.
  function automatic logic reg_legal(input logic [4:0] idx);
    return (idx == 5'd0) || ((idx >= 5'd8) && (idx <= 5'd13));
  endfunction

endpackage

// File: rtl/secuenciador_banco_decodificador.sv
// Combinational decoder for the supported R-type subset and addi;
// flags any unsupported opcode, funct or register index as illegal.
module decodificador_instr
  import secuenciador_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] instr,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        dest,
  output alu_op_t           alu_op,
  output logic              use_imm,
  output logic [DATA_W-1:0] imm_ext,
  output logic              illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rd;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign rd      = instr[15:11];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign imm_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  always_comb begin
    dest    = '0;
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    illegal = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        dest    = rd;
        illegal = 1'b0;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
        if (!(reg_legal(rs) && reg_legal(rt) && reg_legal(rd))) begin
          illegal = 1'b1;
        end
      end
      OPC_ADDI: begin
        dest    = rt;
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        illegal = !(reg_legal(rs) && reg_legal(rt));
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/secuenciador_banco.sv
// Multi-cycle sequencer: accept, decode, register read, ALU execute, writeback.
// Optional retired-instruction counter enabled by defining SECUENCIADOR_PERF_EN.
module secuenciador_banco
  import secuenciador_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic              rf_read_en,
  input  logic [DATA_W-1:0] dato_A,
  input  logic [DATA_W-1:0] dato_B,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              rf_write_en,
`ifdef SECUENCIADOR_PERF_EN
  output logic [15:0]       retired,
`endif
  output logic              busy,
  output logic              error
);

  localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

  estado_t           state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        write_reg_q, write_reg_d;
  alu_op_t           alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SECUENCIADOR_PERF_EN
  logic [15:0]       retired_q, retired_d;
`endif

  logic [4:0]        dec_rs;
  logic [4:0]        dec_rt;
  logic [4:0]        dec_dest;
  alu_op_t           dec_alu_op;
  logic              dec_use_imm;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal;

  // Decodes the latched word, which stays stable until the next accept.
  decodificador_instr #(
    .DATA_W (DATA_W)
  ) u_dec (
    .instr   (instr_q),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .dest    (dec_dest),
    .alu_op  (dec_alu_op),
    .use_imm (dec_use_imm),
    .imm_ext (dec_imm),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      write_reg_q  <= '0;
      alu_op_q     <= ALU_ADD;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
`ifdef SECUENCIADOR_PERF_EN
      retired_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      write_reg_q  <= write_reg_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
`ifdef SECUENCIADOR_PERF_EN
      retired_q    <= retired_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    write_reg_d  = write_reg_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    write_data_d = write_data_q;
    cnt_d        = cnt_q;
`ifdef SECUENCIADOR_PERF_EN
    retired_d    = retired_q;
`endif
    instr_ready  = 1'b0;
    rf_read_en   = 1'b0;
    alu_start    = 1'b0;
    rf_write_en  = 1'b0;
    error        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          error   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          rs_d        = dec_rs;
          rt_d        = dec_rt;
          write_reg_d = dec_dest;
          alu_op_d    = dec_alu_op;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        rf_read_en = 1'b1;
        alu_a_d    = dato_A;
        alu_b_d    = dec_use_imm ? dec_imm : dato_B;
        cnt_d      = '0;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        // The counter is cleared on entry, so zero marks the first EXEC cycle.
        alu_start = (cnt_q == '0);
        if (alu_done) begin
          write_data_d = alu_result;
          cnt_d        = '0;
          state_d      = ST_WB;
        end else if (cnt_q == CNT_W'(ALU_TIMEOUT - 1)) begin
          error   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        rf_write_en = (write_reg_q != 5'd0);
`ifdef SECUENCIADOR_PERF_EN
        retired_d   = retired_q + 16'd1;
`endif
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign rs         = rs_q;
  assign rt         = rt_q;
  assign write_reg  = write_reg_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign write_data = write_data_q;
`ifdef SECUENCIADOR_PERF_EN
  assign retired    = retired_q;
`endif

endmodule

// File: tb/tb_secuenciador_banco.sv
// Self-checking bench for secuenciador_banco: directed cases plus randomized
// instructions checked against a behavioural model; checks retired when SECUENCIADOR_PERF_EN is set.
module tb_secuenciador_banco;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rf_read_en;
  logic [31:0] dato_A;
  logic [31:0] dato_B;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        rf_write_en;
  logic        busy;
  logic        error;
`ifdef SECUENCIADOR_PERF_EN
  logic [15:0] retired;
`endif

  int checks = 0;
  int errors = 0;
  int retired_model = 0;

  secuenciador_banco #(
    .DATA_W      (32),
    .ALU_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs          (rs),
    .rt          (rt),
    .rf_read_en  (rf_read_en),
    .dato_A      (dato_A),
    .dato_B      (dato_B),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .rf_write_en (rf_write_en),
`ifdef SECUENCIADOR_PERF_EN
    .retired     (retired),
`endif
    .busy        (busy),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit reg_ok(input logic [4:0] r);
    return (r == 5'd0) || (r >= 5'd8 && r <= 5'd13);
  endfunction

  task automatic check_retired(input string tag);
`ifdef SECUENCIADOR_PERF_EN
    check(tag, {16'h0, retired}, {16'h0, 16'(retired_model)});
`endif
  endtask

  // One instruction end to end; lat = EXEC cycle (1-based) in which alu_done
  // rises, 0 means never.
  task automatic run(input logic [31:0] w, input logic [31:0] da,
                     input logic [31:0] db, input int lat);
    logic [5:0]  opc, fn;
    logic [4:0]  r_s, r_t, r_d, dst;
    logic        legal, use_imm, done;
    logic [2:0]  op;
    logic [31:0] b_exp, res;
    opc = w[31:26]; fn = w[5:0];
    r_s = w[25:21]; r_t = w[20:16]; r_d = w[15:11];
    use_imm = (opc == 6'h08);
    op = 3'd0; legal = 1'b0; dst = 5'd0;
    if (opc == 6'h00) begin
      legal = 1'b1;
      case (fn)
        6'h20: op = 3'd0;
        6'h22: op = 3'd1;
        6'h24: op = 3'd2;
        6'h25: op = 3'd3;
        6'h2A: op = 3'd4;
        default: legal = 1'b0;
      endcase
      legal = legal && reg_ok(r_s) && reg_ok(r_t) && reg_ok(r_d);
      dst = r_d;
    end else if (use_imm) begin
      legal = reg_ok(r_s) && reg_ok(r_t);
      dst = r_t;
    end
    b_exp = use_imm ? {{16{w[15]}}, w[15:0]} : db;
    case (op)
      3'd0: res = da + b_exp;
      3'd1: res = da - b_exp;
      3'd2: res = da & b_exp;
      3'd3: res = da | b_exp;
      default: res = ($signed(da) < $signed(b_exp)) ? 32'd1 : 32'd0;
    endcase

    check("idle_ready", instr_ready, 1);
    check("idle_busy", busy, 0);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; instr = $urandom;
    check("dec_busy", busy, 1);
    check("dec_ready", instr_ready, 0);
    check("dec_error", error, !legal);
    check("dec_rd_en", rf_read_en, 0);
    if (!legal) begin
      tick();
      check("ill_ready", instr_ready, 1);
      check("ill_err_clr", error, 0);
      check("ill_rd_en", rf_read_en, 0);
      check("ill_we", rf_write_en, 0);
      check_retired("ill_retired");
      return;
    end

    tick();
    check("read_en", rf_read_en, 1);
    check("read_we", rf_write_en, 0);
    check("read_rs", rs, r_s);
    check("read_rt", rt, r_t);
    check("read_start", alu_start, 0);
    dato_A = da; dato_B = db;
    alu_done = 1'($urandom_range(0, 1)); alu_result = $urandom;
    instr_valid = 1'($urandom_range(0, 1));

    tick();
    instr_valid = 1'b0; alu_done = 1'b0;
    dato_A = $urandom; dato_B = $urandom;
    check("exec_alu_a", alu_a, da);
    check("exec_alu_b", alu_b, b_exp);
    check("exec_rd_en", rf_read_en, 0);
    done = 1'b0;
    for (int k = 1; k <= 15 && !done; k++) begin
      check("exec_start", alu_start, (k == 1));
      check("exec_op", alu_op, op);
      check("exec_we", rf_write_en, 0);
      if (k == lat) begin
        alu_done = 1'b1; alu_result = res; done = 1'b1;
      end else begin
        alu_result = $urandom;
      end
      #1;
      check("exec_error", error, (!done && k == 15));
      tick();
      alu_done = 1'b0;
    end

    if (done) begin
      retired_model = (retired_model + 1) % 65536;
      check("wb_busy", busy, 1);
      check("wb_we", rf_write_en, (dst != 5'd0));
      check("wb_reg", write_reg, dst);
      check("wb_data", write_data, res);
      check("wb_rd_en", rf_read_en, 0);
      tick();
    end
    check("end_ready", instr_ready, 1);
    check("end_we", rf_write_en, 0);
    check("end_error", error, 0);
    check_retired("end_retired");
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    if ($urandom_range(0, 9) == 0) r = 5'($urandom);
    else if ($urandom_range(0, 6) == 0) r = 5'd0;
    else r = 5'(8 + $urandom_range(0, 5));
    return r;
  endfunction

  initial begin
    logic [31:0] w;
    logic [5:0]  fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    dato_A = '0; dato_B = '0; alu_done = 1'b0; alu_result = '0;
    #2;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_rd_en", rf_read_en, 0);
    check("rst_we", rf_write_en, 0);
    check("rst_start", alu_start, 0);
    check("rst_rs", rs, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_op", alu_op, 0);
    check("rst_wdata", write_data, 0);
    check_retired("rst_retired");
    tick(); tick();
    rst = 1'b0;
    tick();

    run(32'h01095020, 32'd5, 32'd7, 1);
    run(32'h210BFFFF, 32'd3, 32'h1234_5678, 2);
    run(32'hFC000000, 32'd1, 32'd2, 1);
    run(32'h01095020, 32'd9, 32'd4, 0);
    run(32'h01090020, 32'd1, 32'd1, 1);
    run(32'h01095022, 32'd10, 32'd3, 15);
    run(32'h0109502A, 32'hFFFF_FFFF, 32'd1, 3);
    run(32'h01097020, 32'd1, 32'd1, 1);
    run(32'h01095021, 32'd1, 32'd1, 1);

    // Asynchronous reset in the middle of EXEC.
    instr = 32'h01095020; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    dato_A = 32'd40; dato_B = 32'd2;
    tick();
    check("pre_rst_start", alu_start, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", instr_ready, 1);
    check("arst_start", alu_start, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_rs", rs, 0);
    check("arst_we", rf_write_en, 0);
    retired_model = 0;
    check_retired("arst_retired");
    #1 rst = 1'b0;
    tick();
    check("post_rst_we", rf_write_en, 0);
    run(32'h01095020, 32'd20, 32'd22, 1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: w = {6'h00, pick_reg(), pick_reg(), pick_reg(), 5'd0,
                      ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)]};
        3, 4:    w = {6'h08, pick_reg(), pick_reg(), 16'($urandom)};
        default: w = $urandom;
      endcase
      run(w, $urandom, $urandom,
          ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
